// File: rtl/inst_decode_pkg.sv
// Shared decode constants, ALU codes, FSM encodings and the registered decode record.
// No logic of its own; latency and backpressure belong to the modules that import it.
// Imported by inst_decode and inst_decode_imm_gen.
package inst_decode_pkg;

    localparam int XLEN       = 32;
    localparam int RegAddrBus = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam logic [0:0] ST_ISSUE  = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    localparam logic                  RdEnable    = 1'b1;
    localparam logic                  WrtEnable   = 1'b1;
    localparam logic [RegAddrBus-1:0] ZeroRegAddr = '0;
    localparam logic [XLEN-1:0]       ZeroRegData = '0;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic                  rd_en1;
        logic                  rd_en2;
        logic [RegAddrBus-1:0] rd_addr1;
        logic [RegAddrBus-1:0] rd_addr2;
        logic                  wr_en;
        logic [RegAddrBus-1:0] wr_addr;
        logic [XLEN-1:0]       imm;
        logic [4:0]            alu_op;
        logic [2:0]            funct3;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  branch;
        logic                  jump;
        logic [XLEN-1:0]       pc;
    } dec_t;

    function automatic fmt_e fmt_of(input logic [6:0] opc);
        case (opc)
            OPC_OP:                        return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
            OPC_STORE:                     return FMT_S;
            OPC_BRANCH:                    return FMT_B;
            OPC_LUI, OPC_AUIPC:            return FMT_U;
            OPC_JAL:                       return FMT_J;
            default:                       return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/inst_decode_imm_gen.sv
// Immediate generator: sign-extended immediate selected by the opcode's format.
// Latency: purely combinational.
// Backpressure: none, follows its input.
module inst_decode_imm_gen
    import inst_decode_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = ZeroRegData;
        case (fmt_of(inst[6:0]))
            FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'b0};
            FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = ZeroRegData;
        endcase
    end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage with load-use bubble insertion; RV32M_EN adds the M-extension ops.
// Latency: one cycle to registered outputs; Stall_o_Dec is combinational.
// Backpressure: on a load-use hazard it stalls fetch for exactly one cycle and issues a bubble.
module inst_decode
    import inst_decode_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int REG_AW = RegAddrBus
) (
    input  logic              clk_i_Dec,
    input  logic              Rst_i_Dec,
    input  logic [DATA_W-1:0] Inst_i_Dec,
    input  logic              InstValid_i_Dec,
    input  logic [DATA_W-1:0] PC_i_Dec,
    input  logic              Flush_i_Dec,
    output logic              Stall_o_Dec,
    output logic              RdEn_1_o_Dec,
    output logic              RdEn_2_o_Dec,
    output logic [REG_AW-1:0] Rd_Addr1_o_Dec,
    output logic [REG_AW-1:0] Rd_Addr2_o_Dec,
    output logic              WrEn_o_Dec,
    output logic [REG_AW-1:0] WrAddr_o_Dec,
    output logic [DATA_W-1:0] Imm_o_Dec,
    output logic [4:0]        AluOp_o_Dec,
    output logic [2:0]        Funct3_o_Dec,
    output logic              MemRd_o_Dec,
    output logic              MemWr_o_Dec,
    output logic              Branch_o_Dec,
    output logic              Jump_o_Dec,
    output logic [DATA_W-1:0] PC_o_Dec,
    output logic              Valid_o_Dec,
    output logic              Illegal_o_Dec
);

    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [REG_AW-1:0]     rd, rs1, rs2;
    fmt_e                  fmt;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
    logic [4:0]            alu_op;
    logic                  mem_rd, mem_wr, branch, jump;
    dec_t                  dec;
    dec_t                  out_q;
    logic [0:0]            state_q;
    logic                  ld_pend_q;
    logic [REG_AW-1:0]     ld_rd_q;
    logic                  hazard;

    assign opcode = Inst_i_Dec[6:0];
    assign rd     = Inst_i_Dec[11:7];
    assign funct3 = Inst_i_Dec[14:12];
    assign rs1    = Inst_i_Dec[19:15];
    assign rs2    = Inst_i_Dec[24:20];
    assign funct7 = Inst_i_Dec[31:25];
    assign fmt    = fmt_of(opcode);

    inst_decode_imm_gen u_imm_gen (
        .inst (Inst_i_Dec),
        .imm  (imm)
    );

    always_comb begin
        illegal = 1'b0;
        alu_op  = ALU_ADD;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  alu_op = ALU_ADD;
                            3'b001:  alu_op = ALU_SLL;
                            3'b010:  alu_op = ALU_SLT;
                            3'b011:  alu_op = ALU_SLTU;
                            3'b100:  alu_op = ALU_XOR;
                            3'b101:  alu_op = ALU_SRL;
                            3'b110:  alu_op = ALU_OR;
                            default: alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) alu_op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    F7_MULDIV: begin
`ifdef RV32M_EN
                        case (funct3)
                            3'b000:  alu_op = ALU_MUL;
                            3'b001:  alu_op = ALU_MULH;
                            3'b010:  alu_op = ALU_MULHSU;
                            3'b011:  alu_op = ALU_MULHU;
                            3'b100:  alu_op = ALU_DIV;
                            3'b101:  alu_op = ALU_DIVU;
                            3'b110:  alu_op = ALU_REM;
                            default: alu_op = ALU_REMU;
                        endcase
`else
                        illegal = 1'b1;
`endif
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        // Shift-right immediates: inst[30] picks arithmetic.
                        alu_op  = Inst_i_Dec[30] ? ALU_SRA : ALU_SRL;
                        illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                mem_rd  = 1'b1;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                mem_wr  = 1'b1;
                illegal = funct3[2] || (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                alu_op  = ALU_SUB;
                branch  = 1'b1;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL:   jump = 1'b1;
            OPC_JALR: begin
                jump    = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_LUI:   alu_op = ALU_PASSB;
            OPC_AUIPC: alu_op = ALU_ADD;
            default:   illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.pc    = PC_i_Dec;
        if (illegal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.rd_en1   = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
            dec.rd_en2   = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
            dec.rd_addr1 = dec.rd_en1 ? rs1 : ZeroRegAddr;
            dec.rd_addr2 = dec.rd_en2 ? rs2 : ZeroRegAddr;
            dec.wr_en    = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                           && (rd != ZeroRegAddr) && !mem_wr && !branch;
            dec.wr_addr  = dec.wr_en ? rd : ZeroRegAddr;
            dec.imm      = imm;
            dec.alu_op   = alu_op;
            dec.funct3   = ((fmt == FMT_U) || (fmt == FMT_J)) ? 3'b000 : funct3;
            dec.mem_rd   = mem_rd;
            dec.mem_wr   = mem_wr;
            dec.branch   = branch;
            dec.jump     = jump;
        end
    end

    // A load with rd=x0 leaves ld_rd_q at zero, which never matches.
    assign hazard = InstValid_i_Dec && ld_pend_q && (ld_rd_q != ZeroRegAddr) &&
                    ((dec.rd_en1 && (dec.rd_addr1 == ld_rd_q)) ||
                     (dec.rd_en2 && (dec.rd_addr2 == ld_rd_q)));

    assign Stall_o_Dec = (state_q == ST_ISSUE) && hazard && !Flush_i_Dec;

    always_ff @(posedge clk_i_Dec or negedge Rst_i_Dec) begin
        if (!Rst_i_Dec) begin
            out_q     <= '0;
            state_q   <= ST_ISSUE;
            ld_pend_q <= 1'b0;
            ld_rd_q   <= ZeroRegAddr;
        end else if (Flush_i_Dec || !InstValid_i_Dec) begin
            out_q     <= '0;
            state_q   <= ST_ISSUE;
            ld_pend_q <= 1'b0;
        end else if ((state_q == ST_ISSUE) && hazard) begin
            out_q     <= '0;
            state_q   <= ST_BUBBLE;
            ld_pend_q <= 1'b0;
        end else begin
            out_q     <= dec;
            state_q   <= ST_ISSUE;
            ld_pend_q <= dec.mem_rd;
            ld_rd_q   <= dec.wr_addr;
        end
    end

    assign Valid_o_Dec    = out_q.valid;
    assign Illegal_o_Dec  = out_q.illegal;
    assign RdEn_1_o_Dec   = out_q.rd_en1 & RdEnable;
    assign RdEn_2_o_Dec   = out_q.rd_en2 & RdEnable;
    assign Rd_Addr1_o_Dec = out_q.rd_addr1;
    assign Rd_Addr2_o_Dec = out_q.rd_addr2;
    assign WrEn_o_Dec     = out_q.wr_en & WrtEnable;
    assign WrAddr_o_Dec   = out_q.wr_addr;
    assign Imm_o_Dec      = out_q.imm;
    assign AluOp_o_Dec    = out_q.alu_op;
    assign Funct3_o_Dec   = out_q.funct3;
    assign MemRd_o_Dec    = out_q.mem_rd;
    assign MemWr_o_Dec    = out_q.mem_wr;
    assign Branch_o_Dec   = out_q.branch;
    assign Jump_o_Dec     = out_q.jump;
    assign PC_o_Dec       = out_q.pc;

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: per-format vector table plus load-use, flush and reset sequences.
module tb_inst_decode;

    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SRA = 5'd7, A_AND = 5'd9,
                           A_PASSB = 5'd10, A_MUL = 5'd11;

    localparam logic [31:0] I_LW   = 32'h0000A103;  // lw  x2,0(x1)
    localparam logic [31:0] I_ADD  = 32'h001101B3;  // add x3,x2,x1
    localparam logic [31:0] I_LW3  = 32'h00012183;  // lw  x3,0(x2)
    localparam logic [31:0] I_ADD4 = 32'h00018233;  // add x4,x3,x0
    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst, pc;
    logic        ivld, flush;
    logic        stall, rden1, rden2, wren, memrd, memwr, br, jmp, vld, ill;
    logic [4:0]  a1, a2, wa, alu;
    logic [2:0]  f3;
    logic [31:0] imm, pco;

    typedef struct packed {
        logic        valid;
        logic        ill;
        logic        r1;
        logic        r2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        br;
        logic        j;
        logic [31:0] pc;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        out_t        exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_decode dut (
        .clk_i_Dec       (clk),
        .Rst_i_Dec       (rst_n),
        .Inst_i_Dec      (inst),
        .InstValid_i_Dec (ivld),
        .PC_i_Dec        (pc),
        .Flush_i_Dec     (flush),
        .Stall_o_Dec     (stall),
        .RdEn_1_o_Dec    (rden1),
        .RdEn_2_o_Dec    (rden2),
        .Rd_Addr1_o_Dec  (a1),
        .Rd_Addr2_o_Dec  (a2),
        .WrEn_o_Dec      (wren),
        .WrAddr_o_Dec    (wa),
        .Imm_o_Dec       (imm),
        .AluOp_o_Dec     (alu),
        .Funct3_o_Dec    (f3),
        .MemRd_o_Dec     (memrd),
        .MemWr_o_Dec     (memwr),
        .Branch_o_Dec    (br),
        .Jump_o_Dec      (jmp),
        .PC_o_Dec        (pco),
        .Valid_o_Dec     (vld),
        .Illegal_o_Dec   (ill)
    );

    function automatic out_t eo(input logic il, input logic r1, input logic r2,
                                input logic [4:0] x1, input logic [4:0] x2,
                                input logic we, input logic [4:0] w, input logic [31:0] im,
                                input logic [4:0] op, input logic [2:0] fn,
                                input logic mr, input logic mw, input logic b, input logic jj);
        out_t o;
        o = '{valid: 1'b1, ill: il, r1: r1, r2: r2, a1: x1, a2: x2, we: we, wa: w,
              imm: im, alu: op, f3: fn, mr: mr, mw: mw, br: b, j: jj, pc: 32'h0};
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o = '{valid: vld, ill: ill, r1: rden1, r2: rden2, a1: a1, a2: a2, we: wren, wa: wa,
              imm: imm, alu: alu, f3: f3, mr: memrd, mw: memwr, br: br, j: jmp, pc: pco};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic v, input logic f);
        inst  = i;
        pc    = p;
        ivld  = v;
        flush = f;
        #1;
    endtask

    vec_t vecs[16];
    out_t e;

    initial begin
        vecs[0]  = '{32'h00500093, eo(0,1,0, 0,0, 1,1, 32'h5,        A_ADD,  0, 0,0,0,0)}; // addi
        vecs[1]  = '{32'hFE000EE3, eo(0,1,1, 0,0, 0,0, 32'hFFFFFFFC, A_SUB,  0, 0,0,1,0)}; // beq -4
        vecs[2]  = '{32'h123452B7, eo(0,0,0, 0,0, 1,5, 32'h12345000, A_PASSB,0, 0,0,0,0)}; // lui
        vecs[3]  = '{32'h0020A423, eo(0,1,1, 1,2, 0,0, 32'h8,        A_ADD,  2, 0,1,0,0)}; // sw
        vecs[4]  = '{32'h010000EF, eo(0,0,0, 0,0, 1,1, 32'h10,       A_ADD,  0, 0,0,0,1)}; // jal +16
        vecs[5]  = '{32'h407302B3, eo(0,1,1, 6,7, 1,5, 32'h0,        A_SUB,  0, 0,0,0,0)}; // sub
        vecs[6]  = '{32'h40325213, eo(0,1,0, 4,0, 1,4, 32'h403,      A_SRA,  5, 0,0,0,0)}; // srai
        vecs[7]  = '{32'hFFF47393, eo(0,1,0, 8,0, 1,7, 32'hFFFFFFFF, A_AND,  7, 0,0,0,0)}; // andi -1
        vecs[8]  = '{32'h0000A103, eo(0,1,0, 1,0, 1,2, 32'h0,        A_ADD,  2, 1,0,0,0)}; // lw
        vecs[9]  = '{32'hFFFFF317, eo(0,0,0, 0,0, 1,6, 32'hFFFFF000, A_ADD,  0, 0,0,0,0)}; // auipc
        vecs[10] = '{32'h0000007F, eo(1,0,0, 0,0, 0,0, 32'h0,        5'd0,   0, 0,0,0,0)}; // bad opcode
        vecs[11] = '{32'h00000013, eo(0,1,0, 0,0, 0,0, 32'h0,        A_ADD,  0, 0,0,0,0)}; // nop rd=x0
`ifdef RV32M_EN
        vecs[12] = '{32'h022081B3, eo(0,1,1, 1,2, 1,3, 32'h0,        A_MUL,  0, 0,0,0,0)}; // mul
`else
        vecs[12] = '{32'h022081B3, eo(1,0,0, 0,0, 0,0, 32'h0,        5'd0,   0, 0,0,0,0)}; // mul illegal
`endif
        vecs[13] = '{32'h004280E7, eo(0,1,0, 5,0, 1,1, 32'h4,        A_ADD,  0, 0,0,0,1)}; // jalr
        vecs[14] = '{32'h40001033, eo(1,0,0, 0,0, 0,0, 32'h0,        5'd0,   0, 0,0,0,0)}; // bad funct7
        vecs[15] = '{32'h002090E3, eo(0,1,1, 1,2, 0,0, 32'h800,      A_SUB,  1, 0,0,1,0)}; // bne +2048

        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_outputs", cur(), 128'h0);
        chk("reset_stall", stall, 1'b0);
        cyc();
        cyc();
        #2 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].inst, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
            chk($sformatf("vec%0d_stall", i), stall, 1'b0);
            cyc();
            e    = vecs[i].exp;
            e.pc = 32'h100 + 32'(4 * i);
            chk($sformatf("vec%0d_out", i), cur(), e);
        end

        // Load-use pair: one stall, one bubble, then the consumer issues.
        drive(I_LW, 32'h200, 1'b1, 1'b0);
        cyc();
        drive(I_ADD, 32'h204, 1'b1, 1'b0);
        chk("lu_stall", stall, 1'b1);
        chk("lu_lw_issued", {vld, memrd, wa}, {1'b1, 1'b1, 5'd2});
        cyc();
        chk("lu_bubble", cur(), 128'h0);
        chk("lu_bubble_nostall", stall, 1'b0);
        cyc();
        e    = eo(0,1,1, 2,1, 1,3, 32'h0, A_ADD, 0, 0,0,0,0);
        e.pc = 32'h204;
        chk("lu_add", cur(), e);

        // Dependent back-to-back loads stall once each.
        drive(I_LW, 32'h300, 1'b1, 1'b0);
        cyc();
        drive(I_LW3, 32'h304, 1'b1, 1'b0);
        chk("bb_stall1", stall, 1'b1);
        cyc();
        chk("bb_hold_nostall", stall, 1'b0);
        cyc();
        chk("bb_lw3", {vld, memrd, wa, a1}, {1'b1, 1'b1, 5'd3, 5'd2});
        drive(I_ADD4, 32'h308, 1'b1, 1'b0);
        chk("bb_stall2", stall, 1'b1);
        cyc();
        chk("bb_bubble2", vld, 1'b0);
        cyc();
        chk("bb_add", {vld, a1, wa}, {1'b1, 5'd3, 5'd4});

        // Flush wins over a live hazard and clears the load tracker.
        drive(I_LW, 32'h400, 1'b1, 1'b0);
        cyc();
        drive(I_ADD, 32'h404, 1'b1, 1'b1);
        chk("fl_stall", stall, 1'b0);
        cyc();
        chk("fl_bubble", cur(), 128'h0);
        drive(I_ADD, 32'h408, 1'b1, 1'b0);
        chk("fl_ldpend_clr", stall, 1'b0);
        cyc();
        chk("fl_add", {vld, a1, a2, wa}, {1'b1, 5'd2, 5'd1, 5'd3});

        // An invalid slot also clears the load tracker.
        drive(I_LW, 32'h500, 1'b1, 1'b0);
        cyc();
        drive(I_ADD, 32'h504, 1'b0, 1'b0);
        chk("iv_stall", stall, 1'b0);
        cyc();
        chk("iv_bubble", vld, 1'b0);
        drive(I_ADD, 32'h508, 1'b1, 1'b0);
        chk("iv_ldpend_clr", stall, 1'b0);
        cyc();

        // Asynchronous reset clears registered outputs without a clock edge.
        drive(I_ADDI, 32'h600, 1'b1, 1'b0);
        cyc();
        chk("ar_before", {vld, wa}, {1'b1, 5'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async", cur(), 128'h0);
        cyc();
        #2 rst_n = 1'b1;

        // Reset while in BUBBLE, then the held instruction is re-decoded.
        drive(I_LW, 32'h700, 1'b1, 1'b0);
        cyc();
        drive(I_ADD, 32'h704, 1'b1, 1'b0);
        chk("rs_stall", stall, 1'b1);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("rs_zero", {cur(), stall}, 129'h0);
        cyc();
        #2 rst_n = 1'b1;
        #1;
        chk("rs_after_nostall", stall, 1'b0);
        cyc();
        chk("rs_redecode", {vld, a1, a2, wa, pco}, {1'b1, 5'd2, 5'd1, 5'd3, 32'h704});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_decode.md
# inst_decode

- Instruction decode stage of the 5-stage RV32I pipeline.
- Sits between the IF_ID register and the register file / ID_EXE register. It takes the fetched instruction and produces registered read requests (enables and addresses) for RegsFile, plus the control, immediate and destination fields consumed by EXE.
- Detects load-use hazards, which forwarding cannot cover, and inserts exactly one bubble while holding fetch.

## Interface
- DATA_W, 32: instruction, PC and immediate width.
- REG_AW, 5: register address width (`RegAddrBus`).
- clk_i_Dec  in  1  pipeline clock; all state updates on the rising edge.
- Rst_i_Dec  in  1  reset, asynchronous, active-low.
- Inst_i_Dec  in  DATA_W  instruction from IF_ID.
- InstValid_i_Dec  in  1  Inst_i_Dec/PC_i_Dec valid.
- PC_i_Dec  in  DATA_W  PC of Inst_i_Dec.
- Flush_i_Dec  in  1  taken branch/jump from EXE; kill the instruction in decode.
- Stall_o_Dec  out  1  hold PC and IF_ID this cycle (combinational).
- RdEn_1_o_Dec / RdEn_2_o_Dec  out  1  read enables to RegsFile.
- Rd_Addr1_o_Dec / Rd_Addr2_o_Dec  out  REG_AW  rs1/rs2 to RegsFile.
- WrEn_o_Dec  out  1  rd write enable to ID_EXE.
- WrAddr_o_Dec  out  REG_AW  rd.
- Imm_o_Dec  out  DATA_W  sign-extended immediate.
- AluOp_o_Dec  out  5  ALU operation code.
- Funct3_o_Dec  out  3  funct3 passthrough (branch/load/store width).
- MemRd_o_Dec / MemWr_o_Dec  out  1  load / store.
- Branch_o_Dec / Jump_o_Dec  out  1  conditional branch / JAL-JALR.
- PC_o_Dec  out  DATA_W  PC of the issued instruction.
- Valid_o_Dec  out  1  outputs describe a real instruction.
- Illegal_o_Dec  out  1  unrecognised opcode/funct.

## Operation
- Formats decoded: R, I (OP-IMM, LOAD, JALR), S, B, U (LUI, AUIPC), J (JAL). Anything else sets Illegal_o_Dec and Valid_o_Dec, with all enables 0.
- Read enables:
  - RdEn_1 is 1 for R/I/S/B.
  - RdEn_2 is 1 for R/S/B.
  - Unused address outputs are `ZeroRegAddr`.
- Write enable: WrEn is 1 for R/I/U/J only when rd≠0. An instruction with rd=0 has WrEn=0.
- Immediate: built per format with bit 31 as the sign.
  - B and J immediates have bit 0 = 0.
  - U immediate is {inst[31:12], 12'b0}.
  - R format gives Imm=0.
- SUB/SRA select on inst[30] for R. SRAI uses inst[30] for OP-IMM shifts.
- Load tracker: registered LdPend flag and LdRd address, both taken from the last issued instruction.
- Load-use hazard: LdPend and LdRd≠0 and ((RdEn_1 and rs1==LdRd) or (RdEn_2 and rs2==LdRd)), with InstValid_i_Dec=1.
- FSM has two states:
  - ISSUE: if hazard and not Flush, then Stall_o_Dec=1, register a bubble, go to BUBBLE. Otherwise register the decoded instruction.
  - BUBBLE: Stall_o_Dec=0. Decode the held instruction normally. Always return to ISSUE.
- Bubble: Valid, WrEn, RdEn_1/2, MemRd, MemWr, Branch, Jump and Illegal all 0. Other fields are 0.
- Flush_i_Dec has priority over everything:
  - Register a bubble.
  - Clear LdPend.
  - Force Stall_o_Dec=0.
  - Next state is ISSUE.
- InstValid_i_Dec=0 registers a bubble and clears LdPend.

## Timing
- Latency: one cycle from Inst_i_Dec to all registered outputs. RegsFile adds its own cycle.
- Stall_o_Dec is combinational from the inputs and state. No path runs from Stall_o_Dec back into the inputs.
- A load-use pair costs exactly one bubble. Back-to-back loads with a dependency each stall once.
- Reset: all outputs are 0, including Valid_o_Dec and Stall_o_Dec. LdPend=0 and the state is ISSUE.
- Asserting reset mid-stall clears BUBBLE immediately. The held instruction is re-decoded after release.

## Configuration
- RV32M_EN: when defined, opcode OP with funct7=0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU AluOp codes (R format, WrEn per rd).
- When undefined, those encodings set Illegal_o_Dec=1.

## Structure
- In define.v:
  - opcode constants
  - AluOp codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, the M-extension codes)
  - FSM state encodings
  - `RdEnable`/`WrtEnable`/`ZeroRegAddr`/`ZeroRegData`
- Sub-module imm_gen: combinational, Inst in, Imm out, format selected by opcode.

## Test plan
- addi x1,x0,5 (0x00500093) -> next cycle RdEn_1=1, Addr1=0, RdEn_2=0, WrEn=1, WrAddr=1, Imm=5, Valid=1.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3) -> Stall_o_Dec=1 for one cycle, then a bubble (Valid=0), then add issued with Addr1=2, Addr2=1.
- beq x0,x0,-4 (0xFE000EE3) -> Imm=0xFFFFFFFC, Branch=1, WrEn=0, RdEn_1=RdEn_2=1.
- lui x5,0x12345 (0x123452B7) -> Imm=0x12345000, WrAddr=5, RdEn_1=RdEn_2=0.
- Flush_i_Dec=1 in the same cycle as a load-use hazard -> Stall_o_Dec=0, bubble registered, LdPend cleared. Async reset mid-BUBBLE -> all outputs 0 immediately.
- mul x3,x1,x2 (0x022081B3) -> with RV32M_EN, AluOp=MUL and Illegal=0. Without it, Illegal=1, Valid=1 and all enables 0.
